hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Sequences the front end of the 5-stage pipeline: it drives write-enable and flush/bubble controls for the PC,
//  the IF/ID buffer and the ID/EX buffer. Handles load-use stalls, taken-branch shadow flushes and data-memory wait
//  freezes, and keeps saturating stall/flush event counters for debug. Sits beside the IF/ID and ID/EX buffers;
//  outputs are consumed in the same cycle.
// PARAMETERS
//  REG_W        6   register-address width (rs/rt/rd fields)
//  FLUSH_CYCLES 2   IF/ID+ID/EX flush cycles per taken branch (>=1)
//  CNT_W        16  width of stall_cnt / flush_cnt
//  ZERO_EXEMPT  1   1: rd==0 never causes a load-use hazard
// PORTS
//  clk          in   1      clock, all state updates on posedge
//  rst          in   1      synchronous, active-high reset
//  id_rs        in   REG_W  source reg 1 of instruction in ID
//  id_rt        in   REG_W  source reg 2 of instruction in ID
//  id_uses_rt   in   1      1: id_rt is a real source operand
//  ex_mem_read  in   1      instruction in EX is a load
//  ex_rd        in   REG_W  destination reg of instruction in EX
//  br_taken     in   1      branch/jump in EX resolved taken (1-cycle pulse per branch)
//  dmem_wait    in   1      data memory not ready; whole pipe must hold
//  pc_write     out  1      PC register load enable
//  ifid_write   out  1      IF/ID buffer load enable
//  ifid_flush   out  1      IF/ID buffer loads NOP (0) instead of in_inst
//  idex_bubble  out  1      ID/EX buffer loads all-zero control (bubble)
//  state_o      out  2      current state: 0 RUN, 1 FLUSH, 2 WAIT
//  stall_cnt    out  CNT_W  cycles with pc_write==0 since reset, saturates at all-ones
//  flush_cnt    out  CNT_W  taken-branch flush events since reset, saturates at all-ones
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state<=RUN, flush counter fc<=0, stall_cnt<=0, flush_cnt<=0. While rst is high the
//    outputs are forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
//  - lu_hazard = ex_mem_read & (ex_rd!=0 | !ZERO_EXEMPT) & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
//  - Outputs are combinational from state + inputs (Mealy), zero latency. Next state is registered.
//  - RUN, evaluated in priority order:
//     1. dmem_wait: all four controls = 0 (freeze, br_taken held by frozen EX). Next state: WAIT.
//     2. br_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; flush_cnt+1.
//        If FLUSH_CYCLES>1: fc<=FLUSH_CYCLES-1, next state FLUSH; otherwise stay in RUN.
//     3. lu_hazard: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1 (one bubble; hazard clears next cycle).
//     4. Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
//  - FLUSH: if dmem_wait, all controls are 0 and fc/state hold. Otherwise pc_write=1, ifid_write=1, ifid_flush=1,
//    idex_bubble=1, fc<=fc-1, and the next state is RUN when fc==1. br_taken and lu_hazard are ignored here
//    (the instructions involved are being killed).
//  - WAIT: all four controls are 0 while dmem_wait=1. On the first cycle dmem_wait=0, the controls are still 0
//    (one recovery cycle) and the next state is RUN.
//  - stall_cnt increments on every non-reset cycle with pc_write==0. Both counters saturate and never wrap.
//  - Reset mid-FLUSH or mid-WAIT: immediately returns to RUN; pending flush count is discarded.
//  - state encoding 3 is unreachable; if it occurs, next state is RUN with RUN outputs.
// TESTING
//  1. rst=1 for 2 cycles -> pc_write=0, ifid_flush=1, idex_bubble=1; after release state_o=0, counters=0.
//  2. ex_mem_read=1, ex_rd=5, id_rs=5 -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle;
//     stall_cnt=1. Repeat with ex_rd=0 -> no stall.
//  3. br_taken pulse in RUN, FLUSH_CYCLES=2 -> ifid_flush=1 for 2 consecutive cycles, state 0->1->0, flush_cnt=1.
//  4. br_taken and lu_hazard in the same cycle -> flush wins, idex_bubble=1, pc_write=1; stall_cnt unchanged.
//  5. dmem_wait=1 for 3 cycles in RUN -> controls 0 for 4 cycles (3 + recovery), state 2 then 0, stall_cnt=4.
//  6. dmem_wait=1 during FLUSH with fc=1 -> hold in FLUSH; after release, one flush cycle, then RUN.
//     CNT_W=4 with 20 stalls -> stall_cnt=15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Front-end pipeline sequencer for the 5-stage pipe. Generates the PC,
//   IF/ID and ID/EX load/flush/bubble controls for load-use stalls,
//   taken-branch shadow flushes and data-memory wait freezes. Also keeps
//   saturating stall/flush event counters for debug.
//
//   Controls are Mealy outputs (state + current inputs) and are consumed by
//   the neighbouring pipeline buffers in the same cycle. Only the state, the
//   flush down-counter and the debug counters are registered.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous, active-high reset
//   id_rs/id_rt  source registers of the instruction in ID
//   id_uses_rt   id_rt is a real source operand
//   ex_mem_read  instruction in EX is a load
//   ex_rd        destination register of the instruction in EX
//   br_taken     branch/jump in EX resolved taken (1-cycle pulse)
//   dmem_wait    data memory not ready, whole pipe holds
//   pc_write     PC load enable
//   ifid_write   IF/ID load enable
//   ifid_flush   IF/ID loads NOP
//   idex_bubble  ID/EX loads all-zero control
//   state_o      current state: 0 RUN, 1 FLUSH, 2 WAIT
//   stall_cnt    cycles with pc_write==0 since reset (saturating)
//   flush_cnt    taken-branch flush events since reset (saturating)
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int REG_W        = 6,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16,
    parameter int ZERO_EXEMPT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             br_taken,
    input  logic             dmem_wait,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // The flush down-counter only ever holds 1..FLUSH_CYCLES-1.
    localparam int               FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_ONE  = FC_W'(1);

    state_t          state, state_nxt;
    logic [FC_W-1:0] fc, fc_nxt;
    logic            flush_evt;
    logic            lu_hazard;
    logic            rd_counts;

    // With ZERO_EXEMPT, r0 is hardwired so a load into it can never be a hazard.
    assign rd_counts = (ex_rd != '0) || (ZERO_EXEMPT == 0);
    assign lu_hazard = ex_mem_read && rd_counts &&
                       ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    assign state_o = state;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        state_nxt   = state;
        fc_nxt      = fc;
        flush_evt   = 1'b0;

        case (state)
            S_FLUSH: begin
                if (dmem_wait) begin
                    // Whole pipe frozen: hold the remaining flush count.
                    {pc_write, ifid_write, ifid_flush, idex_bubble} = 4'b0000;
                end else begin
                    // Branch and load-use inputs belong to killed instructions.
                    {pc_write, ifid_write, ifid_flush, idex_bubble} = 4'b1111;
                    fc_nxt = fc - FC_ONE;
                    if (fc == FC_ONE) begin
                        state_nxt = S_RUN;
                    end
                end
            end

            S_WAIT: begin
                // Controls stay low for one extra recovery cycle after dmem_wait drops.
                {pc_write, ifid_write, ifid_flush, idex_bubble} = 4'b0000;
                if (!dmem_wait) begin
                    state_nxt = S_RUN;
                end
            end

            default: begin
                // S_RUN, and the unreachable encoding 3 recovers through RUN behaviour.
                state_nxt = S_RUN;
                if (dmem_wait) begin
                    // EX is frozen too, so a pending br_taken is presented again later.
                    {pc_write, ifid_write, ifid_flush, idex_bubble} = 4'b0000;
                    state_nxt = S_WAIT;
                end else if (br_taken) begin
                    {pc_write, ifid_write, ifid_flush, idex_bubble} = 4'b1111;
                    flush_evt = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        fc_nxt    = FC_LOAD;
                        state_nxt = S_FLUSH;
                    end
                end else if (lu_hazard) begin
                    // Hold PC and IF/ID for one cycle, insert a single bubble into EX.
                    {pc_write, ifid_write, ifid_flush, idex_bubble} = 4'b0001;
                end
            end
        endcase

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            fc        <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            fc    <= fc_nxt;
            if (!pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Self-checking bench for hazard_stall_ctrl. A default instance is checked
//   cycle by cycle against an expected-control scoreboard; a second instance
//   with 4-bit counters shares the stimulus and is used for saturation.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int REG_W = 6;

    typedef struct packed {
        logic [3:0] ctrl;   // {pc_write, ifid_write, ifid_flush, idex_bubble}
        logic [1:0] st;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_uses_rt, ex_mem_read, br_taken, dmem_wait;

    logic             pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [1:0]       state_o;
    logic [15:0]      stall_cnt, flush_cnt;

    logic             s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble;
    logic [1:0]       s_state_o;
    logic [3:0]       s_stall_cnt, s_flush_cnt;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_stall, exp_flush, exp_stall_s, exp_flush_s;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_W(REG_W), .FLUSH_CYCLES(2), .CNT_W(16), .ZERO_EXEMPT(1)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_taken(br_taken), .dmem_wait(dmem_wait),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .state_o(state_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_stall_ctrl #(.REG_W(REG_W), .FLUSH_CYCLES(2), .CNT_W(4), .ZERO_EXEMPT(1)) dut_small (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_taken(br_taken), .dmem_wait(dmem_wait),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_bubble(s_idex_bubble), .state_o(s_state_o), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt)
    );

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic idle();
        rst = 1'b0; id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; br_taken = 1'b0; dmem_wait = 1'b0;
    endtask

    // Called just after a negedge with inputs already driven. Pushes the
    // expectation, compares the combinational outputs, updates the counter
    // model and returns at the following negedge.
    task automatic cyc(input logic [3:0] ectrl, input logic [1:0] est);
        exp_t e;
        expq.push_back('{ctrl: ectrl, st: est});
        #1;
        e = expq.pop_front();
        total++;
        if ({pc_write, ifid_write, ifid_flush, idex_bubble} !== e.ctrl) begin
            bad++;
            $display("FAIL ctrl t=%0t got=%b exp=%b", $time,
                     {pc_write, ifid_write, ifid_flush, idex_bubble}, e.ctrl);
        end
        total++;
        if (state_o !== e.st) begin
            bad++;
            $display("FAIL state t=%0t got=%0d exp=%0d", $time, state_o, e.st);
        end
        if (rst) begin
            exp_stall = 0; exp_flush = 0; exp_stall_s = 0; exp_flush_s = 0;
        end else begin
            if (!e.ctrl[3]) begin
                exp_stall++;
                if (exp_stall_s < 15) exp_stall_s++;
            end
            // The only RUN-state cycle with all four controls high is an accepted branch.
            if (e.ctrl == 4'b1111 && e.st == 2'd0) begin
                exp_flush++;
                if (exp_flush_s < 15) exp_flush_s++;
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_cnt(input string name);
        total++;
        if (stall_cnt !== 16'(exp_stall)) begin
            bad++;
            $display("FAIL %s stall_cnt got=%0d exp=%0d", name, stall_cnt, exp_stall);
        end
        total++;
        if (flush_cnt !== 16'(exp_flush)) begin
            bad++;
            $display("FAIL %s flush_cnt got=%0d exp=%0d", name, flush_cnt, exp_flush);
        end
        total++;
        if (s_stall_cnt !== 4'(exp_stall_s)) begin
            bad++;
            $display("FAIL %s small stall_cnt got=%0d exp=%0d", name, s_stall_cnt, exp_stall_s);
        end
        total++;
        if (s_flush_cnt !== 4'(exp_flush_s)) begin
            bad++;
            $display("FAIL %s small flush_cnt got=%0d exp=%0d", name, s_flush_cnt, exp_flush_s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(4'b0011, 2'd0);
        cyc(4'b0011, 2'd0);
        chk_cnt("reset");
        rst = 1'b0;
        cyc(4'b1100, 2'd0);
        chk_cnt("after_reset");
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_rd = 6'd5; id_rs = 6'd5;
        cyc(4'b0001, 2'd0);
        ex_mem_read = 1'b0;
        cyc(4'b1100, 2'd0);
        chk_cnt("lu_rs");
        // r0 destination is exempt
        ex_mem_read = 1'b1; ex_rd = 6'd0; id_rs = 6'd0;
        cyc(4'b1100, 2'd0);
        // rt match only counts when rt is a real operand
        ex_rd = 6'd7; id_rs = 6'd3; id_rt = 6'd7; id_uses_rt = 1'b1;
        cyc(4'b0001, 2'd0);
        id_uses_rt = 1'b0;
        cyc(4'b1100, 2'd0);
        // not a load: no stall even on a match
        ex_mem_read = 1'b0; id_rs = 6'd7;
        cyc(4'b1100, 2'd0);
        chk_cnt("lu_rt");
        idle();
    endtask

    task automatic test_branch();
        br_taken = 1'b1;
        cyc(4'b1111, 2'd0);
        br_taken = 1'b0;
        cyc(4'b1111, 2'd1);
        cyc(4'b1100, 2'd0);
        chk_cnt("branch");
    endtask

    task automatic test_branch_vs_hazard();
        br_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 6'd9; id_rs = 6'd9;
        cyc(4'b1111, 2'd0);
        br_taken = 1'b0;            // hazard still present but ignored in FLUSH
        cyc(4'b1111, 2'd1);
        idle();
        cyc(4'b1100, 2'd0);
        chk_cnt("br_vs_lu");
    endtask

    task automatic test_dmem_wait();
        dmem_wait = 1'b1;
        cyc(4'b0000, 2'd0);
        cyc(4'b0000, 2'd2);
        cyc(4'b0000, 2'd2);
        dmem_wait = 1'b0;
        cyc(4'b0000, 2'd2);         // recovery cycle
        cyc(4'b1100, 2'd0);
        chk_cnt("dmem_wait");
    endtask

    task automatic test_wait_in_flush();
        br_taken = 1'b1;
        cyc(4'b1111, 2'd0);
        br_taken = 1'b0; dmem_wait = 1'b1;
        cyc(4'b0000, 2'd1);
        cyc(4'b0000, 2'd1);
        dmem_wait = 1'b0;
        cyc(4'b1111, 2'd1);
        cyc(4'b1100, 2'd0);
        chk_cnt("wait_in_flush");
    endtask

    task automatic test_back_to_back();
        // branch held by frozen EX across a wait, then taken
        dmem_wait = 1'b1; br_taken = 1'b1;
        cyc(4'b0000, 2'd0);
        dmem_wait = 1'b0;
        cyc(4'b0000, 2'd2);
        cyc(4'b1111, 2'd0);
        br_taken = 1'b0;
        cyc(4'b1111, 2'd1);
        br_taken = 1'b1;            // next branch right after the flush ends
        cyc(4'b1111, 2'd0);
        br_taken = 1'b0;
        cyc(4'b1111, 2'd1);
        cyc(4'b1100, 2'd0);
        chk_cnt("back_to_back");
    endtask

    task automatic test_reset_mid_flush();
        br_taken = 1'b1;
        cyc(4'b1111, 2'd0);
        br_taken = 1'b0; rst = 1'b1;
        cyc(4'b0011, 2'd1);
        rst = 1'b0;
        cyc(4'b1100, 2'd0);
        chk_cnt("reset_mid_flush");
    endtask

    task automatic test_saturation();
        dmem_wait = 1'b1;
        cyc(4'b0000, 2'd0);
        for (int i = 0; i < 18; i++) cyc(4'b0000, 2'd2);
        dmem_wait = 1'b0;
        cyc(4'b0000, 2'd2);
        cyc(4'b1100, 2'd0);
        chk_cnt("stall_sat");
        for (int i = 0; i < 17; i++) begin
            br_taken = 1'b1;
            cyc(4'b1111, 2'd0);
            br_taken = 1'b0;
            cyc(4'b1111, 2'd1);
        end
        cyc(4'b1100, 2'd0);
        chk_cnt("flush_sat");
    endtask

    initial begin
        exp_stall = 0; exp_flush = 0; exp_stall_s = 0; exp_flush_s = 0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_branch_vs_hazard();
        test_dmem_wait();
        test_wait_in_flush();
        test_back_to_back();
        test_reset_mid_flush();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
